// File: rtl/counter_pkg.sv
// Shared counter types: FSM state encoding and direction constants.
// Imported by updown_counter_p and its future cascade wrapper.
package counter_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter_p.sv
// Synchronous up/down counter, modulus MAX+1, clamped load, one-shot halt.
// Ports: CLK, RST_N (sync, active-low), EN (count/cascade in), Mode (1=up),
//   LOAD/D (parallel load), ONESHOT (halt at terminal), Q (count),
//   TC (combinational cascade carry), DONE (registered one-shot flag).
module updown_counter_p
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 2**WIDTH - 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             Mode,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             ONESHOT,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             DONE
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

    state_t           state;
    logic [WIDTH-1:0] q_r;
    logic             done_r;
    logic [WIDTH-1:0] term;
    logic             at_term;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] step_val;

    // Terminal value depends on the direction currently requested.
    assign term    = (Mode == DIR_UP) ? MAXV : '0;
    assign at_term = (q_r == term);

    assign load_val = (D > MAXV) ? MAXV : D;

    // Off-terminal step; the wrap case is handled separately so that
    // down-counting from 0 lands on MAX rather than all-ones.
    always_comb begin
        step_val = q_r;
        if (Mode == DIR_UP) begin
            step_val = q_r + 1'b1;
        end else begin
            step_val = q_r - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            q_r    <= '0;
            done_r <= 1'b0;
            state  <= RUN;
        end else if (LOAD) begin
            q_r    <= load_val;
            done_r <= 1'b0;
            state  <= RUN;
        end else if (EN && state == RUN) begin
            if (!at_term) begin
                q_r <= step_val;
            end else if (!ONESHOT) begin
                q_r <= (Mode == DIR_UP) ? '0 : MAXV;
            end else begin
                // Hold at terminal and freeze until reload or reset.
                done_r <= 1'b1;
                state  <= HALT;
            end
        end
    end

    // A halted stage must never carry into the next one.
    assign TC   = EN & at_term & (state == RUN);
    assign Q    = q_r;
    assign DONE = done_r;

endmodule

// File: tb/tb_updown_counter_p.sv
// Scoreboard bench for updown_counter_p (WIDTH=4, MAX=9) and a two-stage
// decade cascade built from two instances.
module tb_updown_counter_p;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       EN = 1'b1;
    logic       Mode = 1'b1;
    logic       LOAD = 1'b0;
    logic [3:0] D = 4'd7;
    logic       ONESHOT = 1'b0;
    logic [3:0] Q;
    logic       TC;
    logic       DONE;

    logic       c_rstn = 1'b0;
    logic       c_en = 1'b0;
    logic       c_mode = 1'b1;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_done, hi_done;

    typedef struct {
        bit         chain;
        logic [7:0] q;
        logic       done;
        logic       tc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 CLK = ~CLK;

    updown_counter_p #(.WIDTH(4), .MAX(9)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .Mode(Mode), .LOAD(LOAD),
        .D(D), .ONESHOT(ONESHOT), .Q(Q), .TC(TC), .DONE(DONE)
    );

    updown_counter_p #(.WIDTH(4), .MAX(9)) u_lo (
        .CLK(CLK), .RST_N(c_rstn), .EN(c_en), .Mode(c_mode), .LOAD(1'b0),
        .D(4'd0), .ONESHOT(1'b0), .Q(lo_q), .TC(lo_tc), .DONE(lo_done)
    );

    updown_counter_p #(.WIDTH(4), .MAX(9)) u_hi (
        .CLK(CLK), .RST_N(c_rstn), .EN(lo_tc), .Mode(c_mode), .LOAD(1'b0),
        .D(4'd0), .ONESHOT(1'b0), .Q(hi_q), .TC(hi_tc), .DONE(hi_done)
    );

    // Monitor: each cycle, 2 time units after the edge, compare the oldest
    // pending expectation against the DUT outputs.
    always begin
        exp_t       e;
        logic [7:0] aq;
        logic       ad, at;
        @(posedge CLK);
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chain) begin
                aq = {hi_q, lo_q};
                ad = lo_done | hi_done;
                at = hi_tc;
            end else begin
                aq = {4'd0, Q};
                ad = DONE;
                at = TC;
            end
            n_tests++;
            if (aq !== e.q || ad !== e.done || at !== e.tc) begin
                n_fail++;
                $display("FAIL %s: Q=%0h DONE=%0b TC=%0b, expected Q=%0h DONE=%0b TC=%0b",
                         e.name, aq, ad, at, e.q, e.done, e.tc);
            end
        end
    end

    task automatic step(input logic rstn, input logic en, input logic mode,
                        input logic load, input logic [3:0] d,
                        input logic os, input logic [3:0] eq,
                        input logic edone, input logic etc,
                        input string name);
        exp_t e;
        @(negedge CLK);
        RST_N = rstn; EN = en; Mode = mode;
        LOAD = load; D = d; ONESHOT = os;
        @(posedge CLK);
        #1;
        e.chain = 1'b0; e.q = {4'd0, eq};
        e.done = edone; e.tc = etc; e.name = name;
        sb.push_back(e);
    endtask

    task automatic cstep(input logic rstn, input logic en, input logic mode,
                         input logic [3:0] ehi, input logic [3:0] elo,
                         input logic etc, input string name);
        exp_t e;
        @(negedge CLK);
        c_rstn = rstn; c_en = en; c_mode = mode;
        @(posedge CLK);
        #1;
        e.chain = 1'b1; e.q = {ehi, elo};
        e.done = 1'b0; e.tc = etc; e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        // Reset held two cycles with EN=1, D=7, up mode.
        step(0, 1, 1, 0, 7, 0, 0, 0, 0, "reset0");
        step(0, 1, 1, 0, 7, 0, 0, 0, 0, "reset1");

        // Decade up wrap: 1..9 then 0; TC only while Q=9.
        for (int i = 1; i <= 10; i++) begin
            step(1, 1, 1, 0, 0, 0, 4'(i % 10), 0, (i == 9), "up_wrap");
        end

        // Load clamp: D=15 -> 9; TC gated by EN=0.
        step(1, 0, 1, 1, 15, 0, 9, 0, 0, "load_clamp");
        step(1, 0, 1, 0, 0, 0, 9, 0, 0, "hold_en0");
        // Down wrap from 1: 0 (TC) then MAX.
        step(1, 0, 0, 1, 1, 0, 1, 0, 0, "load1");
        step(1, 1, 0, 0, 0, 0, 0, 0, 1, "down_to0");
        step(1, 1, 0, 0, 0, 0, 9, 0, 0, "down_wrap");

        // One-shot up from 7.
        step(1, 0, 1, 1, 7, 1, 7, 0, 0, "os_load7");
        step(1, 1, 1, 0, 0, 1, 8, 0, 0, "os_8");
        step(1, 1, 1, 0, 0, 1, 9, 0, 1, "os_9_tc");
        step(1, 1, 1, 0, 0, 1, 9, 1, 0, "os_halt");
        step(1, 1, 1, 0, 0, 1, 9, 1, 0, "os_hold");
        step(1, 1, 1, 0, 0, 0, 9, 1, 0, "halt_os_clr");
        step(1, 1, 0, 0, 0, 0, 9, 1, 0, "halt_mode");
        step(1, 0, 1, 1, 3, 0, 3, 0, 0, "reload3");
        step(1, 1, 1, 0, 0, 0, 4, 0, 0, "resume");

        // Simultaneous events.
        step(1, 1, 1, 1, 4, 0, 4, 0, 0, "load_over_en");
        step(1, 1, 1, 0, 0, 0, 5, 0, 0, "to5");
        step(1, 1, 0, 0, 0, 0, 4, 0, 0, "mode_flip");
        step(0, 1, 1, 1, 8, 0, 0, 0, 0, "rst_over_load");

        // Cascade: 25 enabled cycles from 0 gives {2,5}.
        cstep(0, 0, 1, 0, 0, 0, "c_reset");
        for (int i = 1; i <= 25; i++) begin
            cstep(1, 1, 1, 4'(i / 10), 4'(i % 10), 0, "c_up");
        end
        // Down from {0,0} wraps both stages to {9,9}.
        cstep(0, 0, 0, 0, 0, 0, "c_reset2");
        cstep(1, 1, 0, 9, 9, 0, "c_down_wrap");
        cstep(1, 1, 0, 9, 8, 0, "c_down");

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(posedge CLK);
            #3;
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
